rw_progress_tracker: RTL and testbench
======================================

# rw_progress_tracker

Stateful successor to the lane's combinational read/write hazard check. It owns one progress slot per in-flight vector instruction and keeps per-operand read counters, a write counter, the instruction length and captured hazard rows for each slot. Each cycle it produces `readable_o` / `writable_o` for the operand requester. It also retires slots on completion and scrubs stale hazard columns, so slots can be reused safely.

## Interface
- `NrVInsn`, 8, number of instruction slots (≥2).
- `NrHazardOperands`, 3, read operands tracked per instruction.
- `CntWidth`, 16, width of length and progress counters.
- `clk_i  in  1  clock`
- `rst_i  in  1  reset, synchronous, active-high`
- `issue_valid_i  in  1  issue request`
- `issue_id_i  in  $clog2(NrVInsn)  target slot`
- `issue_len_i  in  CntWidth  element groups to read/write`
- `issue_opmask_i  in  NrHazardOperands  operands actually read`
- `issue_read_hazard_i  in  NrVInsn×NrHazardOperands  [k][j]: operand j reads what slot k writes (RAW)`
- `issue_write_hazard_i  in  NrVInsn×NrHazardOperands  [k][j]: this insn writes what slot k operand j reads (WAR)`
- `issue_ready_o  out  1  slot issue_id_i is FREE`
- `read_fire_i  in  NrVInsn×NrHazardOperands  one group read`
- `write_fire_i  in  NrVInsn  one group written`
- `release_i  in  NrVInsn  free a DONE slot`
- `readable_o  out  NrVInsn×NrHazardOperands`
- `writable_o  out  NrVInsn`
- `done_o  out  NrVInsn  slot in DONE`

## Operation
- Per-slot FSM:
  - FREE → ACTIVE on accepted issue.
  - ACTIVE → DONE when write_cnt == len and every read_cnt == len.
  - DONE → FREE on `release_i`.
  - `release_i` in FREE/ACTIVE is ignored.
- Issue is accepted iff `issue_valid_i && issue_ready_o`.
  - On accept: len latched, write_cnt=0.
  - read_cnt[j]=0 if `opmask[j]`, else len.
  - Hazard rows are captured ANDed with (slot k ACTIVE) and with k≠issue_id; self bits are forced to 0.
- `issue_len_i`=0: the slot enters DONE directly at the next edge.
- Counters increment by 1 on fire only when the corresponding readable/writable output is high in that cycle. Otherwise the fire is ignored (protocol error; the bench asserts it never occurs). Counters never exceed len.
- `readable_o[i][j]` = ACTIVE[i] ∧ read_cnt[i][j] < len[i] ∧ ∀k: (¬rhaz[i][k][j] ∨ read_cnt[i][j] < write_cnt[k]).
- `writable_o[i]` = ACTIVE[i] ∧ write_cnt[i] < len[i] ∧ ∀k,j: (¬whaz[i][k][j] ∨ write_cnt[i] < read_cnt[k][j]).
- Column scrub: on the edge where slot k enters DONE, bits rhaz[*][k][*] and whaz[*][k][*] are cleared in all rows. A finished producer or consumer therefore never blocks a longer instruction.
- Simultaneous events:
  - Release and issue of the same slot in one cycle: release wins, issue not accepted (`issue_ready_o` was 0).
  - Issue of slot i in the same cycle slot k enters DONE: captured bits toward k are dropped.
  - Fires on different slots/operands in one cycle are all applied.
- Reset applies mid-operation at any time: all slots FREE, counters/len/hazards 0.

## Timing
- All outputs are combinational from registered state only; there is no input→output path, except `issue_ready_o` from `issue_id_i`.
- Reset values: `readable_o`=0, `writable_o`=0, `done_o`=0. `issue_ready_o`=1 for any id.
- Issue accepted at edge t: readable/writable may assert in cycle t+1.
- Fire in cycle t: counter updated at edge t, new readable/writable visible in t+1. A RAW consumer can fire at most one cycle behind each producer write (back-to-back throughput 1/cycle).
- Last fire in cycle t: `done_o` high in t+1, scrub visible in t+1; `issue_ready_o` for that id stays 0 until the cycle after release.

## Test plan
- Reset: assert `rst_i` 2 cycles mid-traffic → all outputs 0, `done_o`=0, `issue_ready_o`=1; slot 3 reissue accepted next cycle.
- Slot 0, len 4, opmask 3'b001, no hazards; fire read op0 and write every cycle → both high for 4 cycles; `done_o[0]`=1 in cycle 5. Release → `issue_ready_o`(id 0)=1 next cycle.
- RAW: slot 0 len 4 writer; slot 1 len 4 with rhaz[1][0][0]. `readable_o[1][0]`=0 until the first write of slot 0; with writes every cycle, reads trail by exactly 1 cycle; 4 reads total.
- WAR: slot 0 reads op1 len 4; slot 1 len 4 with whaz[1][0][1]. Hold reads → `writable_o[1]`=0. One read → exactly one write allowed, then 0 again.
- Scrub: slot 0 len 2 writer; slot 1 len 8 RAW on slot 0. After slot 0 DONE, `readable_o[1][0]`=1 for the remaining reads, both before and after slot 0 is released and reissued with len 8.
- Corners:
  - Issue len 0 → `done_o` next cycle.
  - Issue to ACTIVE slot → ignored, state unchanged.
  - Release+issue same slot same cycle → slot FREE, no issue.
  - Fire while not readable → counter unchanged.

Source files
------------

// File: rtl/rw_progress_tracker.sv
// Per-slot progress tracker for in-flight vector instructions: read/write
// counters, captured RAW/WAR hazard rows and readable/writable generation.
module rw_progress_tracker #(
  parameter int unsigned NrVInsn          = 8,
  parameter int unsigned NrHazardOperands = 3,
  parameter int unsigned CntWidth         = 16,
  localparam int unsigned IdWidth         = $clog2(NrVInsn)
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        issue_valid_i,
  input  logic [IdWidth-1:0]                          issue_id_i,
  input  logic [CntWidth-1:0]                         issue_len_i,
  input  logic [NrHazardOperands-1:0]                 issue_opmask_i,
  input  logic [NrVInsn-1:0][NrHazardOperands-1:0]    issue_read_hazard_i,
  input  logic [NrVInsn-1:0][NrHazardOperands-1:0]    issue_write_hazard_i,
  output logic                                        issue_ready_o,
  input  logic [NrVInsn-1:0][NrHazardOperands-1:0]    read_fire_i,
  input  logic [NrVInsn-1:0]                          write_fire_i,
  input  logic [NrVInsn-1:0]                          release_i,
  output logic [NrVInsn-1:0][NrHazardOperands-1:0]    readable_o,
  output logic [NrVInsn-1:0]                          writable_o,
  output logic [NrVInsn-1:0]                          done_o
);

  typedef logic [CntWidth-1:0] cnt_t;
  typedef logic [NrVInsn-1:0][NrHazardOperands-1:0] haz_row_t;
  typedef enum logic [1:0] {SlotFree, SlotActive, SlotDone} slot_state_e;

  slot_state_e state_q     [NrVInsn];
  slot_state_e state_d     [NrVInsn];
  cnt_t        len_q       [NrVInsn];
  cnt_t        len_d       [NrVInsn];
  cnt_t        write_cnt_q [NrVInsn];
  cnt_t        write_cnt_d [NrVInsn];
  cnt_t        read_cnt_q  [NrVInsn][NrHazardOperands];
  cnt_t        read_cnt_d  [NrVInsn][NrHazardOperands];
  haz_row_t    rhaz_q      [NrVInsn];
  haz_row_t    rhaz_d      [NrVInsn];
  haz_row_t    whaz_q      [NrVInsn];
  haz_row_t    whaz_d      [NrVInsn];

  logic [NrVInsn-1:0] active;
  logic [NrVInsn-1:0] enter_done;
  logic               issue_accept;

  always_comb begin
    for (int unsigned i = 0; i < NrVInsn; i++) begin
      active[i] = (state_q[i] == SlotActive);
      done_o[i] = (state_q[i] == SlotDone);
    end
  end

  assign issue_ready_o = (state_q[issue_id_i] == SlotFree);
  assign issue_accept  = issue_valid_i && issue_ready_o;

  // A RAW consumer may read group n only once producer k has written past n.
  always_comb begin
    readable_o = '0;
    for (int unsigned i = 0; i < NrVInsn; i++) begin
      for (int unsigned j = 0; j < NrHazardOperands; j++) begin
        readable_o[i][j] = active[i] && (read_cnt_q[i][j] < len_q[i]);
        for (int unsigned k = 0; k < NrVInsn; k++) begin
          if (rhaz_q[i][k][j] && !(read_cnt_q[i][j] < write_cnt_q[k])) begin
            readable_o[i][j] = 1'b0;
          end
        end
      end
    end
  end

  // A WAR writer may overwrite group n only once every reader k,j has passed n.
  always_comb begin
    writable_o = '0;
    for (int unsigned i = 0; i < NrVInsn; i++) begin
      writable_o[i] = active[i] && (write_cnt_q[i] < len_q[i]);
      for (int unsigned k = 0; k < NrVInsn; k++) begin
        for (int unsigned j = 0; j < NrHazardOperands; j++) begin
          if (whaz_q[i][k][j] && !(write_cnt_q[i] < read_cnt_q[k][j])) begin
            writable_o[i] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    logic full;
    enter_done = '0;
    for (int unsigned i = 0; i < NrVInsn; i++) begin
      state_d[i]     = state_q[i];
      len_d[i]       = len_q[i];
      rhaz_d[i]      = rhaz_q[i];
      whaz_d[i]      = whaz_q[i];
      write_cnt_d[i] = write_cnt_q[i] + cnt_t'(write_fire_i[i] && writable_o[i]);
      full           = (write_cnt_d[i] == len_q[i]);
      for (int unsigned j = 0; j < NrHazardOperands; j++) begin
        read_cnt_d[i][j] = read_cnt_q[i][j] + cnt_t'(read_fire_i[i][j] && readable_o[i][j]);
        full             = full && (read_cnt_d[i][j] == len_q[i]);
      end
      enter_done[i] = active[i] && full;
      case (state_q[i])
        SlotActive: if (full)         state_d[i] = SlotDone;
        SlotDone:   if (release_i[i]) state_d[i] = SlotFree;
        default:    state_d[i] = state_q[i];
      endcase
    end

    // Scrub the hazard column of every slot finishing this cycle.
    for (int unsigned i = 0; i < NrVInsn; i++) begin
      for (int unsigned k = 0; k < NrVInsn; k++) begin
        if (enter_done[k]) begin
          rhaz_d[i][k] = '0;
          whaz_d[i][k] = '0;
        end
      end
    end

    // Issue row capture also drops columns being scrubbed on this same edge.
    if (issue_accept) begin
      state_d[issue_id_i]     = (issue_len_i == '0) ? SlotDone : SlotActive;
      len_d[issue_id_i]       = issue_len_i;
      write_cnt_d[issue_id_i] = '0;
      for (int unsigned j = 0; j < NrHazardOperands; j++) begin
        read_cnt_d[issue_id_i][j] = issue_opmask_i[j] ? '0 : issue_len_i;
      end
      for (int unsigned k = 0; k < NrVInsn; k++) begin
        if (active[k] && !enter_done[k] && (IdWidth'(k) != issue_id_i)) begin
          rhaz_d[issue_id_i][k] = issue_read_hazard_i[k];
          whaz_d[issue_id_i][k] = issue_write_hazard_i[k];
        end else begin
          rhaz_d[issue_id_i][k] = '0;
          whaz_d[issue_id_i][k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NrVInsn; i++) begin
        state_q[i]     <= SlotFree;
        len_q[i]       <= '0;
        write_cnt_q[i] <= '0;
        rhaz_q[i]      <= '0;
        whaz_q[i]      <= '0;
        for (int unsigned j = 0; j < NrHazardOperands; j++) begin
          read_cnt_q[i][j] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      write_cnt_q <= write_cnt_d;
      read_cnt_q  <= read_cnt_d;
      rhaz_q      <= rhaz_d;
      whaz_q      <= whaz_d;
    end
  end

endmodule

// File: tb/tb_rw_progress_tracker.sv
// Scoreboard bench for rw_progress_tracker: expectations are queued with the
// stimulus of a cycle and checked against the outputs after the next edge.
module tb_rw_progress_tracker;

  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_DN  = 2;
  localparam int K_RDY = 3;
  localparam int K_RDV = 4;
  localparam int K_WRV = 5;
  localparam int K_DNV = 6;

  typedef struct {
    string tag;
    int    kind;
    int    i;
    int    j;
    int    val;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic [2:0]       issue_id;
  logic [15:0]      issue_len;
  logic [2:0]       issue_opmask;
  logic [7:0][2:0]  rh;
  logic [7:0][2:0]  wh;
  logic             issue_ready;
  logic [7:0][2:0]  rf;
  logic [7:0]       wf;
  logic [7:0]       rel;
  logic [7:0][2:0]  readable;
  logic [7:0]       writable;
  logic [7:0]       done;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  rw_progress_tracker #(
    .NrVInsn(8),
    .NrHazardOperands(3),
    .CntWidth(16)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .issue_valid_i       (issue_valid),
    .issue_id_i          (issue_id),
    .issue_len_i         (issue_len),
    .issue_opmask_i      (issue_opmask),
    .issue_read_hazard_i (rh),
    .issue_write_hazard_i(wh),
    .issue_ready_o       (issue_ready),
    .read_fire_i         (rf),
    .write_fire_i        (wf),
    .release_i           (rel),
    .readable_o          (readable),
    .writable_o          (writable),
    .done_o              (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input int i, input int j, input int val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.i = i; e.j = j; e.val = val;
    sb.push_back(e);
  endtask

  task automatic issue(input int id, input int len, input logic [2:0] mask);
    issue_valid  = 1'b1;
    issue_id     = 3'(id);
    issue_len    = 16'(len);
    issue_opmask = mask;
  endtask

  // Apply this cycle's stimulus at the edge, drop pulses, check queued outputs.
  task automatic step();
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    rh = '0; wh = '0; rf = '0; wf = '0; rel = '0;
    while (sb.size() > 0) begin
      exp_t e;
      int   obs;
      e = sb.pop_front();
      case (e.kind)
        K_RD:    obs = int'(readable[e.i][e.j]);
        K_WR:    obs = int'(writable[e.i]);
        K_DN:    obs = int'(done[e.i]);
        K_RDV:   obs = int'(readable);
        K_WRV:   obs = int'(writable);
        K_DNV:   obs = int'(done);
        default: begin
          issue_id = 3'(e.i);
          #1;
          obs = int'(issue_ready);
        end
      endcase
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic push_reset_state();
    push("rst_readable", K_RDV, 0, 0, 0);
    push("rst_writable", K_WRV, 0, 0, 0);
    push("rst_done", K_DNV, 0, 0, 0);
    for (int id = 0; id < 8; id++) push("rst_ready", K_RDY, id, 0, 1);
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_id = '0; issue_len = '0; issue_opmask = '0;
    rh = '0; wh = '0; rf = '0; wf = '0; rel = '0;
    push_reset_state();
    step();
    step();
    rst = 1'b0;

    // Basic: slot 0, len 4, one read operand, no hazards.
    issue(0, 4, 3'b001);
    push("basic_rd0", K_RDV, 0, 0, 1);
    push("basic_wr0", K_WRV, 0, 0, 1);
    push("basic_busy", K_RDY, 0, 0, 0);
    step();
    for (int n = 0; n < 4; n++) begin
      rf[0][0] = 1'b1; wf[0] = 1'b1;
      push("basic_rd", K_RD, 0, 0, (n < 3) ? 1 : 0);
      push("basic_wr", K_WR, 0, 0, (n < 3) ? 1 : 0);
      push("basic_done", K_DNV, 0, 0, (n < 3) ? 0 : 1);
      push("basic_notready", K_RDY, 0, 0, 0);
      step();
    end
    rel[0] = 1'b1;
    push("release_done", K_DNV, 0, 0, 0);
    push("release_ready", K_RDY, 0, 0, 1);
    step();

    // RAW: slot 1 operand 0 reads what slot 0 writes.
    issue(0, 4, 3'b000);
    push("raw_prod_wr", K_WR, 0, 0, 1);
    push("raw_prod_rd", K_RDV, 0, 0, 0);
    step();
    rh[0][0] = 1'b1;
    issue(1, 4, 3'b001);
    push("raw_blocked", K_RD, 1, 0, 0);
    push("raw_cons_wr", K_WR, 1, 0, 1);
    step();
    for (int t = 0; t < 5; t++) begin
      if (t < 4) begin wf[0] = 1'b1; wf[1] = 1'b1; end
      if (t >= 1) rf[1][0] = 1'b1;
      push("raw_trail", K_RD, 1, 0, (t < 4) ? 1 : 0);
      push("raw_prod_wr", K_WR, 0, 0, (t < 3) ? 1 : 0);
      push("raw_done", K_DNV, 0, 0, (t == 3) ? 1 : (t == 4) ? 3 : 0);
      step();
    end
    rel = 8'b0000_0011;
    push("raw_release", K_DNV, 0, 0, 0);
    step();

    // WAR: slot 1 writes what slot 0 operand 1 reads; early writes ignored.
    issue(0, 4, 3'b010);
    push("war_rd", K_RD, 0, 1, 1);
    step();
    wh[0][1] = 1'b1;
    issue(1, 4, 3'b000);
    push("war_blocked", K_WR, 1, 0, 0);
    step();
    for (int h = 0; h < 2; h++) begin
      wf[1] = 1'b1;
      push("war_hold_wr", K_WR, 1, 0, 0);
      push("war_hold_rd", K_RD, 0, 1, 1);
      step();
    end
    rf[0][1] = 1'b1;
    push("war_one_read", K_WR, 1, 0, 1);
    step();
    wf[1] = 1'b1;
    push("war_one_write", K_WR, 1, 0, 0);
    step();
    issue(3, 5, 3'b001);
    push("pre_rst_rd3", K_RD, 3, 0, 1);
    step();

    // Reset mid-traffic, then reissue slot 3.
    rst = 1'b1;
    push_reset_state();
    step();
    step();
    rst = 1'b0;
    issue(3, 1, 3'b001);
    push("reissue_busy", K_RDY, 3, 0, 0);
    push("reissue_rd", K_RD, 3, 0, 1);
    push("reissue_wr", K_WR, 3, 0, 1);
    push("reissue_old0", K_RD, 0, 1, 0);
    push("reissue_done", K_DNV, 0, 0, 0);
    step();
    rf[3][0] = 1'b1; wf[3] = 1'b1;
    push("len1_done", K_DNV, 0, 0, 8);
    push("len1_rd", K_RDV, 0, 0, 0);
    step();
    rel[3] = 1'b1;
    push("len1_release", K_DNV, 0, 0, 0);
    step();

    // Scrub: short producer finishes, long consumer must not stall on it.
    issue(0, 2, 3'b000);
    push("scrub_prod_wr", K_WR, 0, 0, 1);
    step();
    rh[0][0] = 1'b1;
    issue(1, 8, 3'b001);
    push("scrub_blocked", K_RD, 1, 0, 0);
    step();
    wf[0] = 1'b1;
    push("scrub_w1", K_RD, 1, 0, 1);
    step();
    wf[0] = 1'b1;
    push("scrub_prod_done", K_DN, 0, 0, 1);
    push("scrub_w2", K_RD, 1, 0, 1);
    step();
    for (int r = 1; r <= 4; r++) begin
      rf[1][0] = 1'b1;
      push("scrub_read", K_RD, 1, 0, 1);
      step();
    end
    rel[0] = 1'b1;
    push("scrub_rel_done", K_DN, 0, 0, 0);
    push("scrub_rel_ready", K_RDY, 0, 0, 1);
    push("scrub_rel_rd", K_RD, 1, 0, 1);
    step();
    issue(0, 8, 3'b000);
    push("scrub_reissue_rd", K_RD, 1, 0, 1);
    push("scrub_reissue_wr", K_WR, 0, 0, 1);
    step();
    for (int r = 5; r <= 8; r++) begin
      rf[1][0] = 1'b1;
      push("scrub_tail", K_RD, 1, 0, (r < 8) ? 1 : 0);
      step();
    end

    // Issue to an ACTIVE slot is ignored.
    issue(1, 0, 3'b000);
    push("active_issue_done", K_DN, 1, 0, 0);
    push("active_issue_wr", K_WR, 1, 0, 1);
    push("active_issue_rdy", K_RDY, 1, 0, 0);
    step();

    // Fires while blocked must not count.
    rh[0][0] = 1'b1;
    issue(2, 2, 3'b001);
    push("nofire_blocked", K_RD, 2, 0, 0);
    step();
    for (int b = 0; b < 2; b++) begin
      rf[2][0] = 1'b1;
      push("nofire_still", K_RD, 2, 0, 0);
      step();
    end
    for (int w = 0; w < 2; w++) begin
      wf[0] = 1'b1;
      push("nofire_unblock", K_RD, 2, 0, 1);
      step();
    end
    rf[2][0] = 1'b1;
    push("nofire_read1", K_RD, 2, 0, 1);
    step();
    rf[2][0] = 1'b1;
    push("nofire_read2", K_RD, 2, 0, 0);
    step();

    // Zero-length issue, then release+issue of the same slot.
    issue(4, 0, 3'b001);
    push("len0_done", K_DN, 4, 0, 1);
    push("len0_rdy", K_RDY, 4, 0, 0);
    push("len0_rd", K_RD, 4, 0, 0);
    step();
    rel[4] = 1'b1;
    issue(4, 3, 3'b001);
    push("relissue_done", K_DN, 4, 0, 0);
    push("relissue_rdy", K_RDY, 4, 0, 1);
    push("relissue_rd", K_RD, 4, 0, 0);
    push("relissue_wr", K_WR, 4, 0, 0);
    step();

    // Issue in the same cycle its producer finishes: hazard toward it dropped.
    issue(5, 1, 3'b000);
    push("samecyc_prod", K_WR, 5, 0, 1);
    step();
    wf[5] = 1'b1;
    rh[5][0] = 1'b1;
    issue(6, 2, 3'b001);
    push("samecyc_done", K_DN, 5, 0, 1);
    push("samecyc_rd", K_RD, 6, 0, 1);
    step();
    rf[6][0] = 1'b1;
    push("samecyc_rd2", K_RD, 6, 0, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
